forward_unit_pipe: RTL and testbench

FORWARD_UNIT_PIPE -- requirements
Module: forward_unit_pipe

---
 rtl/forward_unit_pipe.sv | 164 ++++++++++++++++
 tb/tb_forward_unit_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/forward_unit_pipe.sv
// Operand forwarding unit for the register-read (RR) stage.
// Two tracking entries follow the instructions one (T1) and two (T2) stages
// ahead of RR. Each RR source operand is routed from the register file,
// from y_ex_mm (T1) or from datafrom_mm_wb (T2). A load sitting in T1 cannot
// be forwarded yet, so a dependent RR instruction is held for one cycle.
module forward_unit_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned AW     = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NSRC*AW-1:0]       id_src_addr,
  input  logic [NSRC*DATA_W-1:0]   id_src_data,
  input  logic [AW-1:0]            id_dst_addr,
  input  logic                     id_wr_en,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        y_ex_mm,
  input  logic [DATA_W-1:0]        datafrom_mm_wb,
  output logic [NSRC*DATA_W-1:0]   foutput,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_count
);

  localparam logic [1:0] SelRf = 2'b00;
  localparam logic [1:0] SelT1 = 2'b01;
  localparam logic [1:0] SelT2 = 2'b10;

  // Tracking entry T1: instruction one stage ahead (result on y_ex_mm).
  logic          t1_valid_q, t1_valid_d;
  logic [AW-1:0] t1_dst_q,   t1_dst_d;
  logic          t1_wr_en_q, t1_wr_en_d;
  logic          t1_load_q,  t1_load_d;

  // Tracking entry T2: instruction two stages ahead (result on datafrom_mm_wb).
  logic          t2_valid_q, t2_valid_d;
  logic [AW-1:0] t2_dst_q,   t2_dst_d;
  logic          t2_wr_en_q, t2_wr_en_d;
  logic          t2_load_q,  t2_load_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NSRC-1:0]   t1_hit;
  logic [NSRC-1:0]   t2_hit;
  logic [NSRC-1:0]   load_hit;
  logic [NSRC*2-1:0] base_sel;
  logic              stall_int;

  // Per-operand hazard detection and priority selection (r0 never forwards).
  always_comb begin
    t1_hit   = '0;
    t2_hit   = '0;
    load_hit = '0;
    base_sel = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      logic [AW-1:0] src;
      logic          src_nz;
      src       = id_src_addr[i*AW +: AW];
      src_nz    = (src != '0);
      t1_hit[i] = t1_valid_q & t1_wr_en_q & (t1_dst_q == src) & src_nz;
      t2_hit[i] = t2_valid_q & t2_wr_en_q & (t2_dst_q == src) & src_nz;
      // Load result does not exist yet while it sits in T1.
      load_hit[i] = t1_hit[i] & t1_load_q;
      if (!src_nz) begin
        base_sel[i*2 +: 2] = SelRf;
      end else if (t1_hit[i] && !t1_load_q) begin
        base_sel[i*2 +: 2] = SelT1;
      end else if (t2_hit[i]) begin
        base_sel[i*2 +: 2] = SelT2;
      end else begin
        base_sel[i*2 +: 2] = SelRf;
      end
    end
  end

  // Load-use stall; a flush squashes the RR instruction so it cannot stall.
  always_comb begin
    stall_int = id_valid & ~flush & (|load_hit);
  end

  // Final select and operand mux; load-dependent operands read regfile while held.
  always_comb begin
    fwd_sel = '0;
    foutput = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (stall_int && load_hit[i]) begin
        fwd_sel[i*2 +: 2] = SelRf;
      end else begin
        fwd_sel[i*2 +: 2] = base_sel[i*2 +: 2];
      end
      case (fwd_sel[i*2 +: 2])
        SelT1:   foutput[i*DATA_W +: DATA_W] = y_ex_mm;
        SelT2:   foutput[i*DATA_W +: DATA_W] = datafrom_mm_wb;
        default: foutput[i*DATA_W +: DATA_W] = id_src_data[i*DATA_W +: DATA_W];
      endcase
    end
  end

  // Pipeline advance: T1 always shifts into T2; T1 takes the RR instruction or a bubble.
  always_comb begin
    t2_valid_d = t1_valid_q;
    t2_dst_d   = t1_dst_q;
    t2_wr_en_d = t1_wr_en_q;
    t2_load_d  = t1_load_q;
    t1_valid_d = 1'b0;
    t1_dst_d   = '0;
    t1_wr_en_d = 1'b0;
    t1_load_d  = 1'b0;
    if (id_valid && !stall_int && !flush) begin
      t1_valid_d = 1'b1;
      t1_dst_d   = id_dst_addr;
      t1_wr_en_d = id_wr_en;
      t1_load_d  = id_is_load;
    end
  end

  // Saturating stall cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_int && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Tracking entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_valid_q <= 1'b0;
      t1_dst_q   <= '0;
      t1_wr_en_q <= 1'b0;
      t1_load_q  <= 1'b0;
      t2_valid_q <= 1'b0;
      t2_dst_q   <= '0;
      t2_wr_en_q <= 1'b0;
      t2_load_q  <= 1'b0;
    end else begin
      t1_valid_q <= t1_valid_d;
      t1_dst_q   <= t1_dst_d;
      t1_wr_en_q <= t1_wr_en_d;
      t1_load_q  <= t1_load_d;
      t2_valid_q <= t2_valid_d;
      t2_dst_q   <= t2_dst_d;
      t2_wr_en_q <= t2_wr_en_d;
      t2_load_q  <= t2_load_d;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall       = stall_int;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_forward_unit_pipe.sv
// Self-checking bench for forward_unit_pipe: vector table with scoreboard,
// plus hand-written reset-during-stall and counter saturation sequences.
module tb_forward_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_src_addr;
  logic [63:0] id_src_data;
  logic [4:0]  id_dst_addr;
  logic        id_wr_en;
  logic        id_is_load;
  logic        flush;
  logic [31:0] y_ex_mm;
  logic [31:0] datafrom_mm_wb;

  logic [63:0] foutput;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_count;

  logic [63:0] sm_foutput;
  logic [3:0]  sm_fwd_sel;
  logic        sm_stall;
  logic [1:0]  sm_stall_count;

  int checks;
  int failures;

  forward_unit_pipe u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_src_addr    (id_src_addr),
    .id_src_data    (id_src_data),
    .id_dst_addr    (id_dst_addr),
    .id_wr_en       (id_wr_en),
    .id_is_load     (id_is_load),
    .flush          (flush),
    .y_ex_mm        (y_ex_mm),
    .datafrom_mm_wb (datafrom_mm_wb),
    .foutput        (foutput),
    .fwd_sel        (fwd_sel),
    .stall          (stall),
    .stall_count    (stall_count)
  );

  forward_unit_pipe #(.CNT_W(2)) u_small (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_src_addr    (id_src_addr),
    .id_src_data    (id_src_data),
    .id_dst_addr    (id_dst_addr),
    .id_wr_en       (id_wr_en),
    .id_is_load     (id_is_load),
    .flush          (flush),
    .y_ex_mm        (y_ex_mm),
    .datafrom_mm_wb (datafrom_mm_wb),
    .foutput        (sm_foutput),
    .fwd_sel        (sm_fwd_sel),
    .stall          (sm_stall),
    .stall_count    (sm_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       fl;
    logic [3:0] sel;
    logic       st;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  sel;
    logic [63:0] fout;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] op_of(input logic [1:0] sel, input logic [31:0] rf);
    case (sel)
      2'b01:   return y_ex_mm;
      2'b10:   return datafrom_mm_wb;
      default: return rf;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] dst, input logic wr, input logic ld, input logic fl);
    id_valid    = v;
    id_src_addr = {s1, s0};
    id_src_data = {32'hB0B0_0000 | {27'd0, s1}, 32'hA0A0_0000 | {27'd0, s0}};
    id_dst_addr = dst;
    id_wr_en    = wr;
    id_is_load  = ld;
    flush       = fl;
  endtask

  task automatic apply(input vec_t vv);
    exp_t e;
    drive(vv.v, vv.s0, vv.s1, vv.dst, vv.wr, vv.ld, vv.fl);
    e.sel  = vv.sel;
    e.fout = {op_of(vv.sel[3:2], id_src_data[63:32]), op_of(vv.sel[1:0], id_src_data[31:0])};
    e.st   = vv.st;
    e.cnt  = vv.cnt;
    sb.push_back(e);
  endtask

  task automatic check_out(input int idx);
    exp_t e;
    string n;
    n = $sformatf("vec%0d", idx);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", n);
    end else begin
      e = sb.pop_front();
      chk({n, "_sel"}, {60'd0, fwd_sel}, {60'd0, e.sel});
      chk({n, "_fout"}, foutput, e.fout);
      chk({n, "_stall"}, {63'd0, stall}, {63'd0, e.st});
      chk({n, "_cnt"}, {48'd0, stall_count}, {48'd0, e.cnt});
    end
  endtask

  initial begin
    int stalls;
    logic exp_st;
    checks   = 0;
    failures = 0;
    y_ex_mm        = 32'h0000_1111;
    datafrom_mm_wb = 32'h0000_ABCD;
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);

    //           v     s0     s1     dst    wr    ld    fl    sel      st    cnt
    vecs[0]  = '{1'b0, 5'd3,  5'd4,  5'd9,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 5'd3,  5'd0,  5'd4,  1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 5'd3,  5'd4,  5'd4,  1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 5'd7,  5'd4,  5'd6,  1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 16'd0};
    vecs[5]  = '{1'b1, 5'd0,  5'd6,  5'd5,  1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 16'd0};
    vecs[6]  = '{1'b1, 5'd5,  5'd6,  5'd7,  1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 16'd0};
    vecs[7]  = '{1'b1, 5'd5,  5'd6,  5'd7,  1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 16'd1};
    vecs[8]  = '{1'b1, 5'd0,  5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 16'd1};
    vecs[9]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 16'd1};
    vecs[10] = '{1'b1, 5'd0,  5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 16'd1};
    vecs[11] = '{1'b1, 5'd5,  5'd2,  5'd9,  1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 16'd1};
    vecs[12] = '{1'b1, 5'd5,  5'd3,  5'd8,  1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 16'd1};
    vecs[13] = '{1'b0, 5'd8,  5'd0,  5'd9,  1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 16'd1};
    vecs[14] = '{1'b1, 5'd9,  5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 16'd1};

    // Outputs while held in reset with a would-be matching operand.
    #3;
    chk("rst_sel", {60'd0, fwd_sel}, 64'd0);
    chk("rst_fout", foutput, id_src_data);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_cnt", {48'd0, stall_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      check_out(i);
      @(posedge clk);
      #1;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of a load-use stall.
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1 drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("midstall_stall", {63'd0, stall}, 64'd1);
    chk("midstall_cnt", {48'd0, stall_count}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", {63'd0, stall}, 64'd0);
    chk("async_rst_cnt", {48'd0, stall_count}, 64'd0);
    chk("async_rst_sel", {60'd0, fwd_sel}, 64'd0);
    chk("async_rst_fout", foutput, id_src_data);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Saturation on the 2-bit counter: lw r5 <- [r5] repeated stalls every other cycle.
    stalls = 0;
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      exp_st = (k % 2) == 1;
      @(negedge clk);
      chk($sformatf("sat%0d_stall", k), {63'd0, sm_stall}, {63'd0, exp_st});
      chk($sformatf("sat%0d_cnt", k), {62'd0, sm_stall_count},
          64'((stalls > 3) ? 3 : stalls));
      if (exp_st) stalls++;
      @(posedge clk);
      #1;
    end
    chk("sat_final_cnt", {62'd0, sm_stall_count}, 64'd3);
    @(negedge clk);
    chk("sat_stall_again", {63'd0, sm_stall}, 64'd1);
    chk("sat_hold_cnt", {62'd0, sm_stall_count}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("sat_rst_stall", {63'd0, sm_stall}, 64'd0);
    chk("sat_rst_cnt", {62'd0, sm_stall_count}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
